flash_qspi_arbiter: RTL and testbench

//  Shares one QSPI flash device between two flash page buffers (e.g. instruction and data caches).
//  - Each requester sees a private QSPI device port: seek via changeAddress, then a word stream.
//  - Device is time-sliced per SLICE_WORDS words, round-robin between active requesters.
//  - Per-requester resume address is tracked; a preempted stream is transparently re-seeked on regrant.

---
 rtl/flash_pkg.sv | 13 +
 rtl/flash_qspi_context.sv | 44 ++++
 rtl/flash_qspi_arbiter.sv | 137 +++++++++++++
 tb/tb_flash_qspi_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_pkg.sv
// Shared types and constants for the QSPI flash arbiter and its per-requester contexts.
package flash_pkg;

  localparam int unsigned FLASH_ADDR_W     = 24;
  localparam int unsigned FLASH_WORD_BYTES = 4;

  typedef enum logic [1:0] {
    StIdle,
    StSeek,
    StStream
  } flash_state_e;

endpackage

// File: rtl/flash_qspi_context.sv
// Per-requester stream context: resume address and outstanding seek request.
module flash_qspi_context
  import flash_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    capture_i,
  input  logic [FLASH_ADDR_W-1:0] addr_i,
  input  logic                    clear_i,
  input  logic                    advance_i,
  output logic [FLASH_ADDR_W-1:0] saved_addr_o,
  output logic                    seek_pending_o
);

  logic [FLASH_ADDR_W-1:0] saved_addr_q, saved_addr_d;
  logic                    seek_pending_q, seek_pending_d;

  // A fresh seek from the requester beats both the delivery advance and the seek completion.
  always_comb begin
    saved_addr_d   = saved_addr_q;
    seek_pending_d = seek_pending_q;
    if (capture_i) begin
      saved_addr_d   = addr_i;
      seek_pending_d = 1'b1;
    end else begin
      if (advance_i) saved_addr_d = saved_addr_q + FLASH_ADDR_W'(FLASH_WORD_BYTES);
      if (clear_i)   seek_pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      saved_addr_q   <= '0;
      seek_pending_q <= 1'b0;
    end else begin
      saved_addr_q   <= saved_addr_d;
      seek_pending_q <= seek_pending_d;
    end
  end

  assign saved_addr_o   = saved_addr_q;
  assign seek_pending_o = seek_pending_q;

endmodule

// File: rtl/flash_qspi_arbiter.sv
// Time-slices one QSPI flash between two page-buffer requesters, re-seeking on every regrant.
module flash_qspi_arbiter
  import flash_pkg::*;
#(
  parameter int unsigned SLICE_WORDS = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req0_enable_i,
  input  logic [FLASH_ADDR_W-1:0] req0_address_i,
  input  logic                    req0_change_address_i,
  input  logic                    req0_request_data_i,
  output logic [31:0]             req0_read_data_o,
  output logic                    req0_read_data_valid_o,
  output logic                    req0_initialised_o,
  output logic                    req0_busy_o,
  input  logic                    req1_enable_i,
  input  logic [FLASH_ADDR_W-1:0] req1_address_i,
  input  logic                    req1_change_address_i,
  input  logic                    req1_request_data_i,
  output logic [31:0]             req1_read_data_o,
  output logic                    req1_read_data_valid_o,
  output logic                    req1_initialised_o,
  output logic                    req1_busy_o,
  output logic                    qspi_enable_o,
  output logic [FLASH_ADDR_W-1:0] qspi_address_o,
  output logic                    qspi_change_address_o,
  output logic                    qspi_request_data_o,
  input  logic [31:0]             qspi_read_data_i,
  input  logic                    qspi_read_data_valid_i,
  input  logic                    qspi_initialised_i,
  input  logic                    qspi_busy_i
);

  localparam int unsigned    CntW    = $clog2(SLICE_WORDS) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SLICE_WORDS - 1);

  flash_state_e    state_q;
  logic            owner_q, rr_last_q, dev_valid_q, dev_owner_q;
  logic [CntW-1:0] word_count_q;

  logic [1:0]              enable, request, change, active, seek_pending;
  logic [1:0]              owner_sel, clear, advance;
  logic [FLASH_ADDR_W-1:0] req_addr   [2];
  logic [FLASH_ADDR_W-1:0] saved_addr [2];
  logic                    seek_fire, stream_valid, owner_pend, pick;

  assign enable  = {req1_enable_i, req0_enable_i};
  assign request = {req1_request_data_i, req0_request_data_i};
  assign change  = {req1_change_address_i, req0_change_address_i};
  assign req_addr[0] = req0_address_i;
  assign req_addr[1] = req1_address_i;

  assign active       = enable & request & {2{qspi_initialised_i}};
  assign owner_sel    = owner_q ? 2'b10 : 2'b01;
  assign seek_fire    = (state_q == StSeek) && !qspi_busy_i;
  assign stream_valid = (state_q == StStream) && qspi_read_data_valid_i;
  assign owner_pend   = seek_pending[owner_q];
  // On a tie the requester not served last wins; otherwise the single active one.
  assign pick         = (active == 2'b11) ? ~rr_last_q : ~active[0];

  // A valid that coincides with an owner re-seek is routed but not counted: it is refetched.
  assign clear   = seek_fire ? owner_sel : 2'b00;
  assign advance = (stream_valid && !owner_pend) ? owner_sel : 2'b00;

  for (genvar i = 0; i < 2; i++) begin : g_ctx
    flash_qspi_context u_ctx (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .capture_i      (change[i]),
      .addr_i         (req_addr[i]),
      .clear_i        (clear[i]),
      .advance_i      (advance[i]),
      .saved_addr_o   (saved_addr[i]),
      .seek_pending_o (seek_pending[i])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      rr_last_q    <= 1'b1;
      dev_valid_q  <= 1'b0;
      dev_owner_q  <= 1'b0;
      word_count_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|active) begin
            owner_q      <= pick;
            rr_last_q    <= pick;
            word_count_q <= '0;
            if (seek_pending[pick] || !dev_valid_q || (dev_owner_q != pick)) state_q <= StSeek;
            else                                                              state_q <= StStream;
          end
        end
        StSeek: begin
          if (!qspi_busy_i) begin
            dev_valid_q  <= 1'b1;
            dev_owner_q  <= owner_q;
            word_count_q <= '0;
            state_q      <= StStream;
          end
        end
        StStream: begin
          if (stream_valid && !owner_pend && (word_count_q != CntLast)) begin
            word_count_q <= word_count_q + 1'b1;
          end
          if (owner_pend) begin
            state_q <= StSeek;
          end else if (!active[owner_q]) begin
            state_q <= StIdle;
          end else if (stream_valid && (word_count_q == CntLast) && active[~owner_q]) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign qspi_enable_o         = |enable;
  assign qspi_change_address_o = seek_fire;
  assign qspi_address_o        = (state_q == StSeek) ? saved_addr[owner_q] : '0;
  assign qspi_request_data_o   = (state_q == StStream) && active[owner_q];

  assign req0_read_data_o       = qspi_read_data_i;
  assign req1_read_data_o       = qspi_read_data_i;
  assign req0_initialised_o     = qspi_initialised_i;
  assign req1_initialised_o     = qspi_initialised_i;
  assign req0_read_data_valid_o = stream_valid && owner_sel[0];
  assign req1_read_data_valid_o = stream_valid && owner_sel[1];
  assign req0_busy_o = seek_pending[0] || (owner_sel[0] && (state_q != StIdle) && qspi_busy_i);
  assign req1_busy_o = seek_pending[1] || (owner_sel[1] && (state_q != StIdle) && qspi_busy_i);

endmodule

// File: tb/tb_flash_qspi_arbiter.sv
// Randomised and directed bench for flash_qspi_arbiter against a cycle-level behavioural model.
module tb_flash_qspi_arbiter;

  localparam int unsigned S = 16;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [1:0]  en = '0, rd = '0, chg = '0;
  logic [23:0] addr [2];
  logic [31:0] rdata0, rdata1, q_rdata = '0;
  logic        v0, v1, init0, init1, b0, b1;
  logic        q_en, q_chg, q_req;
  logic [23:0] q_addr;
  logic        q_valid = 1'b0, q_init = 1'b1, q_busy = 1'b0;

  // Behavioural model: phase 0 = no grant, 1 = seeking, 2 = streaming.
  int          m_st, m_owner, m_rr, m_dev, m_cnt;
  logic [23:0] m_saved [2];
  bit          m_pend  [2];

  int          n_checks = 0, n_err = 0;
  int          valid_pct = 0, busy_pct = 0, init_pct = 100, busy_hold = 0;
  logic [23:0] seek_log [$];
  int          vcount [2];

  always #5 clk_i = ~clk_i;

  flash_qspi_arbiter #(.SLICE_WORDS(S)) dut (
    .clk_i                  (clk_i),
    .rst_i                  (rst_i),
    .req0_enable_i          (en[0]),
    .req0_address_i         (addr[0]),
    .req0_change_address_i  (chg[0]),
    .req0_request_data_i    (rd[0]),
    .req0_read_data_o       (rdata0),
    .req0_read_data_valid_o (v0),
    .req0_initialised_o     (init0),
    .req0_busy_o            (b0),
    .req1_enable_i          (en[1]),
    .req1_address_i         (addr[1]),
    .req1_change_address_i  (chg[1]),
    .req1_request_data_i    (rd[1]),
    .req1_read_data_o       (rdata1),
    .req1_read_data_valid_o (v1),
    .req1_initialised_o     (init1),
    .req1_busy_o            (b1),
    .qspi_enable_o          (q_en),
    .qspi_address_o         (q_addr),
    .qspi_change_address_o  (q_chg),
    .qspi_request_data_o    (q_req),
    .qspi_read_data_i       (q_rdata),
    .qspi_read_data_valid_i (q_valid),
    .qspi_initialised_i     (q_init),
    .qspi_busy_i            (q_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_owner = 0; m_rr = 1; m_dev = -1; m_cnt = 0;
    for (int n = 0; n < 2; n++) begin
      m_saved[n] = '0;
      m_pend[n]  = 1'b0;
    end
  endtask

  // Compare all outputs against the model, then advance the model across the coming edge.
  task automatic eval();
    bit          act [2];
    bit          pd  [2];
    logic [23:0] sv  [2];
    int          st, own, rr, dev, cnt, pick;
    for (int n = 0; n < 2; n++) act[n] = en[n] && rd[n] && q_init;

    chk("qspi_enable", q_en, en[0] | en[1]);
    chk("qspi_change_address", q_chg, m_st == 1 && !q_busy);
    chk("qspi_address", q_addr, (m_st == 1) ? m_saved[m_owner] : 24'h0);
    chk("qspi_request_data", q_req, m_st == 2 && act[m_owner]);
    chk("req0_valid", v0, m_st == 2 && q_valid && m_owner == 0);
    chk("req1_valid", v1, m_st == 2 && q_valid && m_owner == 1);
    chk("req0_busy", b0, m_pend[0] || (m_st != 0 && m_owner == 0 && q_busy));
    chk("req1_busy", b1, m_pend[1] || (m_st != 0 && m_owner == 1 && q_busy));
    chk("req0_rdata", rdata0, q_rdata);
    chk("req1_rdata", rdata1, q_rdata);
    chk("req0_init", init0, q_init);
    chk("req1_init", init1, q_init);

    if (q_chg) seek_log.push_back(q_addr);
    vcount[0] += int'(v0);
    vcount[1] += int'(v1);

    if (rst_i) begin
      model_reset();
      return;
    end

    st = m_st; own = m_owner; rr = m_rr; dev = m_dev; cnt = m_cnt;
    for (int n = 0; n < 2; n++) begin
      sv[n] = m_saved[n];
      pd[n] = m_pend[n];
    end
    if (m_st == 2 && q_valid && !m_pend[m_owner]) begin
      sv[own] = m_saved[own] + 24'd4;
      if (cnt < S - 1) cnt++;
    end
    case (m_st)
      0: if (act[0] || act[1]) begin
        pick = (act[0] && act[1]) ? 1 - m_rr : (act[0] ? 0 : 1);
        own = pick; rr = pick; cnt = 0;
        st = (m_pend[pick] || m_dev != pick) ? 1 : 2;
      end
      1: if (!q_busy) begin
        pd[own] = 1'b0; dev = own; cnt = 0; st = 2;
      end
      default: begin
        if (m_pend[own])                                        st = 1;
        else if (!act[own])                                     st = 0;
        else if (q_valid && m_cnt == S - 1 && act[1 - own])     st = 0;
      end
    endcase
    for (int n = 0; n < 2; n++) if (chg[n]) begin
      sv[n] = addr[n];
      pd[n] = 1'b1;
    end
    m_st = st; m_owner = own; m_rr = rr; m_dev = dev; m_cnt = cnt;
    for (int n = 0; n < 2; n++) begin
      m_saved[n] = sv[n];
      m_pend[n]  = pd[n];
    end
  endtask

  task automatic cyc();
    @(negedge clk_i);
    eval();
    @(posedge clk_i);
    #1;
    q_valid = ($urandom_range(99) < valid_pct);
    q_busy  = (busy_hold > 0) ? 1'b1 : ($urandom_range(99) < busy_pct);
    if (busy_hold > 0) busy_hold--;
    q_init  = ($urandom_range(99) < init_pct);
    q_rdata = $urandom;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    #1;
    chk("rst_change_address", q_chg, 1'b0);
    chk("rst_request_data", q_req, 1'b0);
    chk("rst_req0_valid", v0, 1'b0);
    chk("rst_req1_valid", v1, 1'b0);
    chk("rst_qspi_address", q_addr, 24'h0);
    model_reset();
    cyc();
    rst_i = 1'b0;
    seek_log.delete();
    vcount[0] = 0;
    vcount[1] = 0;
  endtask

  task automatic wait_log(input int n, input string name);
    for (int i = 0; i < 500 && seek_log.size() < n; i++) cyc();
    chk(name, seek_log.size(), n);
  endtask

  initial begin
    addr[0] = '0;
    addr[1] = '0;
    #2;
    do_reset();

    // Solo stream of 40 words from 0x000100.
    valid_pct = 100;
    chg[0] = 1'b1; addr[0] = 24'h000100; en[0] = 1'b1;
    cyc();
    chg[0] = 1'b0; rd[0] = 1'b1;
    for (int i = 0; i < 500 && vcount[0] < 40; i++) cyc();
    chk("solo_req0_words", vcount[0], 40);
    chk("solo_req1_words", vcount[1], 0);
    chk("solo_strobes", seek_log.size(), 1);
    if (seek_log.size() > 0) chk("solo_seek_addr", seek_log[0], 24'h000100);
    chk("solo_model_saved0", m_saved[0], 24'h0001A0);

    // Reset while streaming, then the first seek must come from a zeroed resume address.
    chk("pre_reset_request", q_req, 1'b1);
    do_reset();
    cyc();
    wait_log(1, "post_reset_strobe");
    if (seek_log.size() > 0) chk("post_reset_seek_addr", seek_log[0], 24'h0);
    rd[0] = 1'b0;

    // Contention: four seeks in strict alternation, stale valids discarded across switches.
    do_reset();
    chg = 2'b11; addr[0] = 24'h000000; addr[1] = 24'h010000; en = 2'b11;
    cyc();
    chg = 2'b00; rd = 2'b11;
    wait_log(4, "contention_strobes");
    if (seek_log.size() >= 4) begin
      chk("contention_seek0", seek_log[0], 24'h000000);
      chk("contention_seek1", seek_log[1], 24'h010000);
      chk("contention_seek2", seek_log[2], 24'h000040);
      chk("contention_seek3", seek_log[3], 24'h010040);
    end
    rd = 2'b00;

    // Owner re-seek mid-stream.
    do_reset();
    valid_pct = 70;
    chg[0] = 1'b1; addr[0] = 24'h001000; en[0] = 1'b1;
    cyc();
    chg[0] = 1'b0; rd[0] = 1'b1;
    wait_log(1, "reseek_first_strobe");
    repeat (5) cyc();
    chg[0] = 1'b1; addr[0] = 24'h002000;
    cyc();
    chg[0] = 1'b0;
    wait_log(2, "reseek_second_strobe");
    if (seek_log.size() >= 2) chk("reseek_addr", seek_log[1], 24'h002000);

    // Device busy holds the seek strobe off.
    rd[0] = 1'b0;
    repeat (3) cyc();
    busy_hold = 1000;
    chg[1] = 1'b1; addr[1] = 24'h003000; en[1] = 1'b1;
    cyc();
    chg[1] = 1'b0; rd[1] = 1'b1;
    repeat (8) cyc();
    chk("busy_held_off", seek_log.size(), 2);
    busy_hold = 0;
    repeat (3) cyc();
    chk("busy_single_strobe", seek_log.size(), 3);
    if (seek_log.size() >= 3) chk("busy_seek_addr", seek_log[2], 24'h003000);

    // Randomised traffic.
    valid_pct = 60; busy_pct = 20; init_pct = 97;
    for (int i = 0; i < 4000; i++) begin
      for (int n = 0; n < 2; n++) begin
        if ($urandom_range(99) < 3)  en[n] = ~en[n];
        if ($urandom_range(99) < 8)  rd[n] = ~rd[n];
        chg[n] = ($urandom_range(99) < 4);
        if (chg[n]) addr[n] = ($urandom_range(3) == 0) ? 24'hFFFFF0 : ($urandom & 24'hFFFFFC);
      end
      cyc();
    end
    chg = 2'b00;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
